drv_teclado_display: RTL and testbench
======================================

Name: drv_teclado_display

Overview:
- Single-clock peripheral block that combines a 4x4 matrix keypad scanner with a 3-digit multiplexed 7-segment display driver.
- The scanner drives the columns active-low, reads the rows, and registers the last pressed key as a 5-bit code with a one-cycle change strobe.
- The display driver time-multiplexes three 5-bit digit codes (hundreds/tens/units) onto one common-anode segment bus.
- Internal tick dividers replace external divided clocks; the block sits between the board pins and the top-level datapath.

Parameters:
- KEY_DIV, 500000: clk cycles per keypad scan tick (5 ms at 100 MHz).
- DISP_DIV, 100000: clk cycles per display digit tick (1 ms at 100 MHz).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- fila  in  4  keypad rows; active-low, externally pulled up; asynchronous.
- col  out  4  keypad columns; exactly one bit low at any time.
- digito  out  5  code of last accepted key.
- cambio_digito  out  1  one-clk pulse when digito is updated.
- c  in  5  hundreds digit code.
- d  in  5  tens digit code.
- u  in  5  units digit code.
- enable  out  3  digit anodes, active-low; bit0=u, bit1=d, bit2=c.
- segmentos  out  7  segments, active-low; bit6..0 = g,f,e,d,c,b,a.

Behaviour:
- Reset is synchronous and active-high. Reset values:
  - col=4'b1110.
  - digito=5'h10 (blank).
  - cambio_digito=0.
  - enable=3'b110, with segmentos showing u.
  - Both tick counters=0.
  - Scan column=0; released flag=1.
- Tick generation: a counter counts 0..KEY_DIV-1. key_tick is asserted for one cycle when the count is KEY_DIV-1, then the counter wraps. The display tick works the same way using DISP_DIV.
- fila passes through a 2-FF synchronizer (fila_s) before use.
- Keypad scan, on each key_tick:
  - Sample fila_s for the current column, which has been driven for a full tick period.
  - Then advance the column 0->1->2->3->0 (col rotates 1110->1101->1011->0111).
- Key map, as row,col -> code:
  - r0: 1,2,3,A = 1,2,3,10.
  - r1: 4,5,6,B = 4,5,6,11.
  - r2: 7,8,9,C = 7,8,9,12.
  - r3: *,0,#,D = 14,0,15,13.
- Multiple rows low in one sample: the lowest row index wins.
- Key acceptance:
  - A press is accepted if any row is low, the released flag is 1, and key_tick is active.
  - digito updates on the same edge; cambio_digito=1 for exactly that one clk cycle; released is cleared.
- Release detection:
  - released is set again only after 4 consecutive key_ticks (one full column sweep) with all rows high.
  - A held key therefore never retriggers.
  - A new key pressed while another is held is ignored until everything is released.
- Display: on each display tick, advance digit select u->d->c->u and update enable and segmentos together in the same cycle, so there is no ghosting.
- Segment decode, applied to a 5-bit code:
  - 0..15 decode to hex glyphs 0-9 and A,b,C,d,E,F.
  - 16..31 are blank (7'h7F).
  - Active-low. Examples: '0'=7'b1000000, 'E'=7'b0000110, '4'=7'b0011001.
- c, d and u are sampled combinationally into the segment register at each tick. A change takes effect at the next tick of that digit.
- Reset asserted mid-scan or mid-press returns the block to reset values on the next edge; a pending press is dropped.

Optional Feature:
- Macro DRV_TECLADO_BLANK_LEAD_EN.
- When defined, leading-zero blanking applies:
  - c==0 displays blank.
  - d==0 displays blank when c is 0 or blank.
  - u is never blanked.
- When undefined, all codes are shown as given.

Decomposition:
- Shared package drv_teclado_pkg holds:
  - the key-code constants (KEY_A=10 .. KEY_HASH=15, CODE_BLANK=5'h10);
  - the SEG_BLANK constant;
  - the segment decode function.
- One natural sub-module: seg7_decode, a combinational 5-bit code to active-low 7-bit segments.
- Tick counters and scan logic are inline.

Test Plan (KEY_DIV=4, DISP_DIV=3):
- Reset held 2 cycles -> col=1110, digito=5'h10, cambio_digito=0, enable=110, segmentos=decode(u).
- With no press, run 16 cycles -> col steps 1110,1101,1011,0111,1110 every 4 cycles; cambio_digito stays 0.
- Pull fila[1] low only while col=1101 (key '5') -> digito=5 and a one-cycle cambio_digito on that key_tick; holding for 40 cycles gives no further pulses.
- After a full release sweep, press r3,c2 ('#') -> digito=15, one pulse. Press '#' and '9' simultaneously without release -> the second key is ignored.
- Set c=0, d=4, u=14 -> enable cycles 110,101,011 every 3 cycles with segments 'E'=0000110, '4'=0011001, '0'=1000000. With DRV_TECLADO_BLANK_LEAD_EN, the c slot shows 1111111.
- Set u=5'h1F -> the units slot shows blank 1111111. Assert reset mid-press -> digito returns to 5'h10 with no pulse.

Source files
------------

// File: rtl/drv_teclado_display_pkg.sv
// Shared key codes, segment constants and decode helpers for the keypad/display driver.
package drv_teclado_pkg;

  typedef logic [4:0] code_t;
  typedef logic [6:0] seg_t;

  typedef enum logic [1:0] {
    SEL_U = 2'd0,
    SEL_D = 2'd1,
    SEL_C = 2'd2
  } digit_sel_e;

  localparam code_t KEY_A      = 5'd10;
  localparam code_t KEY_B      = 5'd11;
  localparam code_t KEY_C      = 5'd12;
  localparam code_t KEY_D      = 5'd13;
  localparam code_t KEY_STAR   = 5'd14;
  localparam code_t KEY_HASH   = 5'd15;
  localparam code_t CODE_BLANK = 5'h10;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Active-low glyphs, bit order g,f,e,d,c,b,a.
  function automatic seg_t seg_decode(input code_t code);
    seg_t s;
    case (code)
      5'd0:    s = 7'b1000000;
      5'd1:    s = 7'b1111001;
      5'd2:    s = 7'b0100100;
      5'd3:    s = 7'b0110000;
      5'd4:    s = 7'b0011001;
      5'd5:    s = 7'b0010010;
      5'd6:    s = 7'b0000010;
      5'd7:    s = 7'b1111000;
      5'd8:    s = 7'b0000000;
      5'd9:    s = 7'b0010000;
      5'd10:   s = 7'b0001000;
      5'd11:   s = 7'b0000011;
      5'd12:   s = 7'b1000110;
      5'd13:   s = 7'b0100001;
      5'd14:   s = 7'b0000110;
      5'd15:   s = 7'b0001110;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic code_t key_code(input logic [1:0] row, input logic [1:0] col);
    code_t k;
    case ({row, col})
      4'h0: k = 5'd1;
      4'h1: k = 5'd2;
      4'h2: k = 5'd3;
      4'h3: k = KEY_A;
      4'h4: k = 5'd4;
      4'h5: k = 5'd5;
      4'h6: k = 5'd6;
      4'h7: k = KEY_B;
      4'h8: k = 5'd7;
      4'h9: k = 5'd8;
      4'hA: k = 5'd9;
      4'hB: k = KEY_C;
      4'hC: k = KEY_STAR;
      4'hD: k = 5'd0;
      4'hE: k = KEY_HASH;
      default: k = KEY_D;
    endcase
    return k;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  function automatic logic [2:0] anode_sel(input digit_sel_e sel);
    logic [2:0] a;
    case (sel)
      SEL_D:   a = 3'b101;
      SEL_C:   a = 3'b011;
      default: a = 3'b110;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/drv_teclado_display_if.sv
// Pin-side and datapath-side signals of the keypad/display driver.
// master = the driver block, slave = board pins plus datapath.
interface drv_teclado_display_if;
  import drv_teclado_pkg::*;

  logic [3:0] fila;
  logic [3:0] col;
  code_t      digito;
  logic       cambio_digito;
  code_t      c;
  code_t      d;
  code_t      u;
  logic [2:0] enable;
  seg_t       segmentos;

  modport master (
    input  fila, c, d, u,
    output col, digito, cambio_digito, enable, segmentos
  );

  modport slave (
    output fila, c, d, u,
    input  col, digito, cambio_digito, enable, segmentos
  );
endinterface

// File: rtl/drv_teclado_display_seg7.sv
// Combinational 5-bit code to active-low 7-segment decoder.
// Latency: zero cycles. No backpressure.
module seg7_decode
  import drv_teclado_pkg::*;
(
  input  code_t code,
  output seg_t  seg
);
  assign seg = seg_decode(code);
endmodule

// File: rtl/drv_teclado_display.sv
// 4x4 keypad scanner plus 3-digit multiplexed 7-segment driver; optional DRV_TECLADO_BLANK_LEAD_EN blanks leading zeros.
// Latency: key accepted on a scan tick (2-FF row sync ahead of it); display slot updates on each display tick.
// No backpressure: cambio_digito is a one-cycle strobe the consumer must take when it fires.
module drv_teclado_display
  import drv_teclado_pkg::*;
#(
  parameter int KEY_DIV  = 500000,
  parameter int DISP_DIV = 100000
) (
  input logic                   clk,
  input logic                   reset,
  drv_teclado_display_if.master bus
);

  localparam int KW = (KEY_DIV  > 1) ? $clog2(KEY_DIV)  : 1;
  localparam int DW = (DISP_DIV > 1) ? $clog2(DISP_DIV) : 1;
  localparam logic [KW-1:0] KEY_LAST  = KW'(KEY_DIV - 1);
  localparam logic [DW-1:0] DISP_LAST = DW'(DISP_DIV - 1);

  logic [KW-1:0] key_cnt;
  logic [DW-1:0] disp_cnt;
  logic          key_tick;
  logic          disp_tick;

  assign key_tick  = (key_cnt == KEY_LAST);
  assign disp_tick = (disp_cnt == DISP_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      key_cnt  <= '0;
      disp_cnt <= '0;
    end else begin
      key_cnt  <= key_tick  ? '0 : key_cnt + KW'(1);
      disp_cnt <= disp_tick ? '0 : disp_cnt + DW'(1);
    end
  end

  logic [3:0] fila_m;
  logic [3:0] fila_s;
  logic [1:0] col_idx;
  logic [3:0] col_r;
  code_t      digito_r;
  logic       cambio_r;
  logic       released;
  logic [1:0] rel_cnt;
  logic       row_hit;
  logic [1:0] row_idx;

  assign row_hit = (fila_s != 4'hF);

  always_comb begin
    row_idx = 2'd3;
    if (!fila_s[0])      row_idx = 2'd0;
    else if (!fila_s[1]) row_idx = 2'd1;
    else if (!fila_s[2]) row_idx = 2'd2;
  end

  // The sample at a tick belongs to the column driven during the whole period just ending.
  always_ff @(posedge clk) begin
    if (reset) begin
      fila_m   <= 4'hF;
      fila_s   <= 4'hF;
      col_idx  <= 2'd0;
      col_r    <= 4'b1110;
      digito_r <= CODE_BLANK;
      cambio_r <= 1'b0;
      released <= 1'b1;
      rel_cnt  <= 2'd0;
    end else begin
      fila_m   <= bus.fila;
      fila_s   <= fila_m;
      cambio_r <= 1'b0;
      if (key_tick) begin
        col_idx <= col_idx + 2'd1;
        col_r   <= col_drive(col_idx + 2'd1);
        if (row_hit) begin
          rel_cnt <= 2'd0;
          if (released) begin
            digito_r <= key_code(row_idx, col_idx);
            cambio_r <= 1'b1;
            released <= 1'b0;
          end
        end else if (!released) begin
          // Re-arm only after a full sweep with every row idle.
          if (rel_cnt == 2'd3) begin
            released <= 1'b1;
            rel_cnt  <= 2'd0;
          end else begin
            rel_cnt <= rel_cnt + 2'd1;
          end
        end
      end
    end
  end

  code_t      c_show;
  code_t      d_show;
  code_t      code_nxt;
  seg_t       seg_nxt;
  digit_sel_e sel;
  digit_sel_e sel_nxt;
  logic [2:0] enable_r;
  seg_t       seg_r;

`ifdef DRV_TECLADO_BLANK_LEAD_EN
  assign c_show = (bus.c == 5'd0) ? CODE_BLANK : bus.c;
  assign d_show = ((bus.d == 5'd0) && ((bus.c == 5'd0) || bus.c[4])) ? CODE_BLANK : bus.d;
`else
  assign c_show = bus.c;
  assign d_show = bus.d;
`endif

  always_comb begin
    sel_nxt = SEL_U;
    if (!reset) begin
      case (sel)
        SEL_U:   sel_nxt = SEL_D;
        SEL_D:   sel_nxt = SEL_C;
        default: sel_nxt = SEL_U;
      endcase
    end
  end

  always_comb begin
    code_nxt = bus.u;
    case (sel_nxt)
      SEL_D:   code_nxt = d_show;
      SEL_C:   code_nxt = c_show;
      default: code_nxt = bus.u;
    endcase
  end

  seg7_decode u_seg7 (
    .code (code_nxt),
    .seg  (seg_nxt)
  );

  // Anode and segment registers load on the same edge so no slot ever shows a neighbour's glyph.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel      <= SEL_U;
      enable_r <= anode_sel(SEL_U);
      seg_r    <= seg_nxt;
    end else if (disp_tick) begin
      sel      <= sel_nxt;
      enable_r <= anode_sel(sel_nxt);
      seg_r    <= seg_nxt;
    end
  end

  assign bus.col           = col_r;
  assign bus.digito        = digito_r;
  assign bus.cambio_digito = cambio_r;
  assign bus.enable        = enable_r;
  assign bus.segmentos     = seg_r;

endmodule

// File: tb/tb_drv_teclado_display.sv
// Scoreboard bench for drv_teclado_display with KEY_DIV=4, DISP_DIV=3.
module tb_drv_teclado_display;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  drv_teclado_display_if bus();

  drv_teclado_display #(.KEY_DIV(4), .DISP_DIV(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef DRV_TECLADO_BLANK_LEAD_EN
  localparam logic [6:0] C_ZERO_EXP = 7'b1111111;
`else
  localparam logic [6:0] C_ZERO_EXP = 7'b1000000;
`endif

  // Keypad model: pressed[row][col]; a row reads low when a pressed key sits on the driven column.
  logic [3:0] pressed [4];
  logic [3:0] fila_v;
  always_comb begin
    fila_v = 4'hF;
    for (int r = 0; r < 4; r++) fila_v[r] = ~|(pressed[r] & ~bus.col);
  end
  assign bus.fila = fila_v;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tmo_cnt = 0;
  logic final_req = 1'b0;
  logic done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [4:0]  key_q [$];
  logic [7:0]  col_q [$];   // {col, cycles since previous col change, 0 = untimed}
  logic [13:0] disp_q [$];  // {enable, segmentos, cycles since previous slot change}
  logic [19:0] snap_exp_q [$];
  logic [19:0] snap_msk_q [$];
  string       snap_name_q [$];

  localparam logic [19:0] M_COL = 20'hF0000;
  localparam logic [19:0] M_DIG = 20'h0F800;
  localparam logic [19:0] M_CMB = 20'h00400;
  localparam logic [19:0] M_ALL = 20'hFFFFF;

  function automatic logic [19:0] snap(input logic [3:0] cl, input logic [4:0] dg,
                                       input logic cb, input logic [2:0] en, input logic [6:0] sg);
    return {cl, dg, cb, en, sg};
  endfunction

  task automatic push_snap(input string nm, input logic [19:0] e, input logic [19:0] m);
    snap_exp_q.push_back(e);
    snap_msk_q.push_back(m);
    snap_name_q.push_back(nm);
  endtask

  // Monitor: every comparison happens here, at the falling edge.
  logic [3:0] prev_col = 4'b1110;
  logic [2:0] prev_en = 3'b110;
  int last_col_cyc = 0;
  int last_en_cyc = 0;
  always @(negedge clk) begin
    logic [19:0] act, se, sm;
    logic [7:0]  ce;
    logic [13:0] de;
    logic [4:0]  ke;
    string       sn;
    act = {bus.col, bus.digito, bus.cambio_digito, bus.enable, bus.segmentos};
    if (snap_exp_q.size() > 0) begin
      se = snap_exp_q.pop_front();
      sm = snap_msk_q.pop_front();
      sn = snap_name_q.pop_front();
      checks++;
      if ((act & sm) !== (se & sm)) begin
        failures++;
        $display("FAIL %s actual=%h required=%h mask=%h", sn, act, se, sm);
      end
    end
    if (!reset) begin
      if (bus.cambio_digito === 1'b1) begin
        checks++;
        if (key_q.size() == 0) begin
          failures++;
          $display("FAIL key_pulse unexpected pulse digito=%0d required=no pulse", bus.digito);
        end else begin
          ke = key_q.pop_front();
          if (bus.digito !== ke) begin
            failures++;
            $display("FAIL key_code digito=%0d required=%0d", bus.digito, ke);
          end
        end
      end
      if (bus.col !== prev_col && col_q.size() > 0) begin
        ce = col_q.pop_front();
        checks++;
        if (bus.col !== ce[7:4]) begin
          failures++;
          $display("FAIL col_step col=%b required=%b", bus.col, ce[7:4]);
        end
        if (ce[3:0] != 4'd0) begin
          checks++;
          if (cyc - last_col_cyc != int'(ce[3:0])) begin
            failures++;
            $display("FAIL col_period cycles=%0d required=%0d", cyc - last_col_cyc, ce[3:0]);
          end
        end
      end
      if (bus.enable !== prev_en && disp_q.size() > 0) begin
        de = disp_q.pop_front();
        checks++;
        if ({bus.enable, bus.segmentos} !== de[13:4]) begin
          failures++;
          $display("FAIL disp_slot enable=%b seg=%b required enable=%b seg=%b",
                   bus.enable, bus.segmentos, de[13:11], de[10:4]);
        end
        if (de[3:0] != 4'd0) begin
          checks++;
          if (cyc - last_en_cyc != int'(de[3:0])) begin
            failures++;
            $display("FAIL disp_period cycles=%0d required=%0d", cyc - last_en_cyc, de[3:0]);
          end
        end
      end
    end
    if (bus.col !== prev_col) last_col_cyc = cyc;
    if (bus.enable !== prev_en) last_en_cyc = cyc;
    prev_col = bus.col;
    prev_en  = bus.enable;
    if (final_req && !done) begin
      checks++;
      if (key_q.size() + col_q.size() + disp_q.size() + snap_exp_q.size() != 0) begin
        failures++;
        $display("FAIL drain pending key=%0d col=%0d disp=%0d snap=%0d required=0",
                 key_q.size(), col_q.size(), disp_q.size(), snap_exp_q.size());
      end
      checks++;
      if (tmo_cnt != 0) begin
        failures++;
        $display("FAIL timeout count=%0d required=0", tmo_cnt);
      end
      done = 1'b1;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait for the display to enter the units slot, so the next slots are d, c, u.
  task automatic sync_units();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.enable === 3'b110 && n < 12) begin @(negedge clk); n++; end
    while (bus.enable !== 3'b110 && n < 12) begin @(negedge clk); n++; end
    if (n >= 12) tmo_cnt++;
    #1;
  endtask

  initial begin
    for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;
    bus.c = 5'd0;
    bus.d = 5'd0;
    bus.u = 5'd7;
    reset = 1'b1;

    cycles(2);
    push_snap("reset_state", snap(4'b1110, 5'h10, 1'b0, 3'b110, 7'b1111000), M_ALL);
    col_q.push_back({4'b1101, 4'd0});
    col_q.push_back({4'b1011, 4'd4});
    col_q.push_back({4'b0111, 4'd4});
    col_q.push_back({4'b1110, 4'd4});
    cycles(1);
    reset = 1'b0;
    cycles(17);

    // Key '5' held for 40 cycles: one pulse only.
    key_q.push_back(5'd5);
    pressed[1] = 4'b0010;
    cycles(40);
    pressed[1] = 4'b0000;
    cycles(30);
    push_snap("digito_5", snap(4'h0, 5'd5, 1'b0, 3'h0, 7'h0), M_DIG | M_CMB);

    // '#', then '9' added on the same column while '#' is still held.
    key_q.push_back(5'd15);
    pressed[3] = 4'b0100;
    cycles(20);
    pressed[2] = 4'b0100;
    cycles(40);
    push_snap("digito_hold_hash", snap(4'h0, 5'd15, 1'b0, 3'h0, 7'h0), M_DIG | M_CMB);
    cycles(1);
    pressed[2] = 4'b0000;
    pressed[3] = 4'b0000;
    cycles(30);

    // Display mux: c=0, d=4, u=E.
    bus.c = 5'd0;
    bus.d = 5'd4;
    bus.u = 5'd14;
    sync_units();
    disp_q.push_back({3'b101, 7'b0011001, 4'd0});
    disp_q.push_back({3'b011, C_ZERO_EXP, 4'd3});
    disp_q.push_back({3'b110, 7'b0000110, 4'd3});
    cycles(12);

    // Code 0x1F in the units slot is blank.
    bus.u = 5'h1F;
    sync_units();
    disp_q.push_back({3'b101, 7'b0011001, 4'd0});
    disp_q.push_back({3'b011, C_ZERO_EXP, 4'd3});
    disp_q.push_back({3'b110, 7'b1111111, 4'd3});
    cycles(12);

    // Hex glyphs in the upper slots: c=b, d=0 stays visible since c is non-zero.
    bus.c = 5'd11;
    bus.d = 5'd0;
    bus.u = 5'd9;
    sync_units();
    disp_q.push_back({3'b101, 7'b1000000, 4'd0});
    disp_q.push_back({3'b011, 7'b0000011, 4'd3});
    disp_q.push_back({3'b110, 7'b0010000, 4'd3});
    cycles(12);

    // Reset while a press is propagating: dropped, no pulse afterwards.
    bus.u = 5'h1F;
    pressed[0] = 4'b1111;
    cycles(1);
    reset = 1'b1;
    cycles(2);
    pressed[0] = 4'b0000;
    push_snap("reset_mid_press", snap(4'b1110, 5'h10, 1'b0, 3'b110, 7'b1111111), M_ALL);
    cycles(1);
    reset = 1'b0;
    cycles(30);
    push_snap("digito_after_reset", snap(4'h0, 5'h10, 1'b0, 3'h0, 7'h0), M_DIG | M_CMB);
    cycles(2);

    final_req = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
